eth_gmii_monitor: RTL and testbench
===================================

Name: eth_gmii_monitor

Overview:
- Receive-side checker for the GMII byte stream that the testbench Ethernet generator drives (rxd/rx_dv/rx_er, 8-bit, one byte per rx_clk).
- Strips preamble/SFD, parses the header, checks the incrementing payload pattern and the FCS, then reports one status record per frame.
- Sits directly downstream of the generator in MAC-loopback and PHY-side benches, and is also used standalone as a scoreboard front end.

Parameters:
- MAX_FRM_LEN, 1518, frame length in bytes (DA through FCS) above which `long_err` is set.
- MIN_FRM_LEN, 64, frame length below which `runt_err` is set.
- CHK_PAYLOAD, 1, 1 enables the payload pattern check; 0 forces `payload_err` to 0.

Ports:
- rx_clk  in  1  byte clock.
- reset_n  in  1  asynchronous active-low reset.
- rxd  in  8  GMII receive data.
- rx_dv  in  1  data valid.
- rx_er  in  1  PHY error.
- cntstart  in  8  expected first payload byte.
- cntstep  in  8  payload increment per byte.
- sop  out  1  pulse on the first DA byte.
- eop  out  1  pulse on the last FCS byte.
- frm_done  out  1  one-cycle pulse; status outputs are valid.
- dst  out  48  captured DA, first received byte in [47:40].
- src  out  48  captured SA, same byte order.
- len_type  out  16  length/type field (after VLAN tag if present).
- vlan_tag  out  1  0x8100 seen at the type position.
- frm_len  out  16  bytes from DA through FCS.
- prmbl_err  out  1
- crc_err  out  1
- payload_err  out  1
- phy_err  out  1
- runt_err  out  1
- long_err  out  1
- frm_cnt  out  32  frames completed.
- err_cnt  out  32  frames completed with any error flag set.

Behaviour:
- Reset:
  - Asynchronous reset, active-low on reset_n.
  - All outputs are 0 in reset. The FSM enters IDLE. The CRC register is set to 0xFFFFFFFF.
- FSM states: IDLE, PRMBL, HDR, PAYLD, DROP.
  - IDLE: on rx_dv=1, go to PRMBL and evaluate the current byte as preamble.
  - PRMBL, byte 0x55: stay. Preamble count saturates at 31.
  - PRMBL, byte 0xD5: go to HDR with byte index 0.
    - If zero 0x55 bytes preceded the 0xD5, set prmbl_err; the frame is still parsed.
  - PRMBL, any other byte: set prmbl_err and go to DROP.
  - HDR: bytes 0-5 go to dst, bytes 6-11 go to src, bytes 12-13 go to len_type.
    - If len_type = 0x8100, set vlan_tag, skip 2 TCI bytes, and recapture len_type from the next 2 bytes.
    - Then go to PAYLD.
  - DROP: ignore bytes until rx_dv=0, then emit the frame end.
- Frame end:
  - Triggered by rx_dv falling in HDR, PAYLD or DROP.
  - The last 4 received bytes are the FCS.
  - eop is asserted on the cycle the last byte is present, using a one-cycle lookahead register: the byte stream is delayed 1 cycle internally, so sop and eop lag rxd by 1 cycle.
  - frm_done pulses exactly 2 cycles after rx_dv falls.
  - dst, src, len_type, frm_len and all error flags update on that cycle and are held until the next frm_done.
  - frm_cnt increments at frm_done. err_cnt increments when any error flag is set. Both counters wrap at 2^32.
- FCS:
  - CRC-32 is reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, computed over DA through FCS inclusive.
  - crc_err = (register != 0xC704DD7B) at frame end.
  - crc_err is forced to 1 for frames ended in DROP or with frm_len < 18.
- Payload check:
  - Bytes are classified through a 4-deep byte delay line. A byte leaving the line while rx_dv=1 is payload; the 4 bytes still in the line at frame end are FCS.
  - Expected value: first payload byte = cntstart; each following expected byte = previous expected + cntstep, mod 256.
  - If len_type < 0x0600, only the first len_type payload bytes are checked, and padding is ignored.
  - Any mismatch sets payload_err.
- Error flags:
  - phy_err: set if rx_er=1 on any cycle with rx_dv=1 in the frame.
  - A rx_er=1 with rx_dv=0 (carrier extension or false carrier) is ignored.
  - runt_err = frm_len < MIN_FRM_LEN. long_err = frm_len > MAX_FRM_LEN.
  - frm_len saturates at 0xFFFF.
- Boundaries:
  - Single-cycle rx_dv=0 gaps (IPG of 1) are legal: a new frame's PRMBL can start on the same cycle the previous frame's frm_done is pending; the status pipeline is independent of the FSM.
  - A reset_n assertion mid-frame discards the frame: no frm_done is produced and the counters clear.

Decomposition:
- Package eth_mon_pkg: state enum; constants CRC_INIT, CRC_POLY, CRC_RESIDUE, SFD (0xD5), PRE (0x55), TPID_VLAN (0x8100), LEN_TYPE_THR (0x0600).
- Sub-module eth_crc32_d8: combinational 8-bit-per-step CRC update, crc_in[31:0] + d[7:0] -> crc_out[31:0].

Test Plan:
- Good frame: 7×0x55, 0xD5; DA 00:11:22:33:44:55; SA 66:77:88:99:AA:BB; len 46; cntstart=0x01, cntstep=0x01; valid FCS -> frm_done with frm_len=64 and all error flags 0; frm_cnt=1, err_cnt=0.
- Same frame with FCS byte 0 inverted -> crc_err=1, err_cnt=1; dst, src and len_type are still captured correctly.
- Payload byte 20 = 0x00 instead of 0x15 -> payload_err=1 only. Type-field frame 0x0800 with len 100 -> all 100 bytes are checked and no error is reported.
- Preamble 0x55,0x55,0x5D,0xD5,... -> prmbl_err=1, crc_err=1, frm_done 2 cycles after rx_dv falls.
- VLAN frame with 0x8100, TCI 0x0005, len 0x002E -> vlan_tag=1, len_type=0x002E, frm_len=68, no errors. 40-byte frame -> runt_err=1.
- rx_er pulsed for 1 cycle at payload byte 10 -> phy_err=1. Two back-to-back frames with a 1-cycle gap -> 2 frm_done pulses and frm_cnt=2. reset_n low mid-payload -> no frm_done and frm_cnt=0.

Source files
------------

// File: rtl/eth_mon_pkg.sv
// Shared types and constants for the GMII receive monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRMBL,
        ST_HDR,
        ST_PAYLD,
        ST_DROP
    } state_t;

    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
    // Good-frame residue in normal (MSB-first) bit order; the reflected register is bit-reversed before comparing.
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
    localparam logic [7:0]  SFD          = 8'hD5;
    localparam logic [7:0]  PRE          = 8'h55;
    localparam logic [15:0] TPID_VLAN    = 16'h8100;
    localparam logic [15:0] LEN_TYPE_THR = 16'h0600;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] len_type;
        logic        vlan;
    } hdr_t;

    typedef struct packed {
        logic prmbl_err;
        logic crc_err;
        logic payload_err;
        logic phy_err;
        logic runt_err;
        logic long_err;
    } meta_t;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_gmii_monitor_crc.sv
// Reflected CRC-32 update for one byte, LSB of the byte first.
// Latency: combinational.
// Backpressure: none.
module eth_crc32_d8
    import eth_mon_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/eth_gmii_monitor.sv
// GMII receive checker: strips preamble, parses header, checks payload pattern and FCS.
// Latency: sop/eop lag rxd by 1 cycle; frm_done pulses 2 cycles after rx_dv falls.
// Backpressure: none; GMII is push-only and every byte is consumed on arrival.
module eth_gmii_monitor
    import eth_mon_pkg::*;
#(
    parameter int MAX_FRM_LEN = 1518,
    parameter int MIN_FRM_LEN = 64,
    parameter bit CHK_PAYLOAD = 1'b1
) (
    input  logic        rx_clk,
    input  logic        reset_n,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  cntstart,
    input  logic [7:0]  cntstep,
    output logic        sop,
    output logic        eop,
    output logic        frm_done,
    output logic [47:0] dst,
    output logic [47:0] src,
    output logic [15:0] len_type,
    output logic        vlan_tag,
    output logic [15:0] frm_len,
    output logic        prmbl_err,
    output logic        crc_err,
    output logic        payload_err,
    output logic        phy_err,
    output logic        runt_err,
    output logic        long_err,
    output logic [31:0] frm_cnt,
    output logic [31:0] err_cnt
);

    localparam logic [15:0] MIN_L = 16'(MIN_FRM_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_FRM_LEN);

    state_t          state_q, state_d;
    logic [4:0]      pre_cnt_q, pre_cnt_d, idx_q, idx_d;
    logic [31:0]     crc_q, crc_d, crc_nxt;
    hdr_t            cur_q, cur_d, pend_hdr_q, pend_hdr_d, out_hdr_q, out_hdr_d;
    meta_t           pend_meta_q, pend_meta_d, out_meta_q, out_meta_d;
    logic [15:0]     flen_q, flen_d, pend_len_q, pend_len_d, out_len_q, out_len_d;
    logic            prm_q, prm_d, phy_q, phy_d, perr_q, perr_d;
    logic [7:0]      exp_q, exp_d;
    logic [15:0]     pidx_q, pidx_d;
    logic [3:0][7:0] dl_dat_q, dl_dat_d;
    logic [3:0]      dl_vld_q, dl_vld_d;
    logic            d1_act_q, d1_act_d, sop_q, sop_d;
    logic            pend_vld_q, pend_vld_d, frm_done_q, frm_done_d;
    logic [31:0]     frm_cnt_q, frm_cnt_d, err_cnt_q, err_cnt_d;
    logic            in_frame, frm_end;
    logic [4:0]      pre_base;
    logic [15:0]     flen_inc, lt_nxt;

    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .d       (rxd),
        .crc_out (crc_nxt)
    );

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        idx_d       = idx_q;
        crc_d       = crc_q;
        cur_d       = cur_q;
        flen_d      = flen_q;
        prm_d       = prm_q;
        phy_d       = phy_q;
        perr_d      = perr_q;
        exp_d       = exp_q;
        pidx_d      = pidx_q;
        dl_dat_d    = dl_dat_q;
        dl_vld_d    = dl_vld_q;
        pend_hdr_d  = pend_hdr_q;
        pend_meta_d = pend_meta_q;
        pend_len_d  = pend_len_q;
        out_hdr_d   = out_hdr_q;
        out_meta_d  = out_meta_q;
        out_len_d   = out_len_q;
        frm_cnt_d   = frm_cnt_q;
        err_cnt_d   = err_cnt_q;
        sop_d       = 1'b0;
        pend_vld_d  = 1'b0;
        frm_done_d  = 1'b0;

        in_frame = state_q inside {ST_HDR, ST_PAYLD, ST_DROP};
        frm_end  = in_frame && !rx_dv;
        flen_inc = (flen_q == 16'hFFFF) ? flen_q : flen_q + 16'd1;
        lt_nxt   = {cur_q.len_type[7:0], rxd};
        pre_base = (state_q == ST_IDLE) ? 5'd0 : pre_cnt_q;
        d1_act_d = rx_dv && in_frame;

        // Per-frame accumulators start fresh whenever the line is idle.
        if (state_q == ST_IDLE) begin
            crc_d     = CRC_INIT;
            cur_d     = '0;
            flen_d    = '0;
            prm_d     = 1'b0;
            phy_d     = 1'b0;
            perr_d    = 1'b0;
            exp_d     = cntstart;
            pidx_d    = '0;
            dl_vld_d  = '0;
            pre_cnt_d = '0;
            idx_d     = '0;
        end

        if (rx_dv && rx_er) phy_d = 1'b1;

        case (state_q)
            ST_IDLE, ST_PRMBL: begin
                if (!rx_dv) begin
                    state_d = ST_IDLE;
                end else if (rxd == PRE) begin
                    state_d   = ST_PRMBL;
                    pre_cnt_d = (pre_base == 5'd31) ? pre_base : pre_base + 5'd1;
                end else if (rxd == SFD) begin
                    state_d = ST_HDR;
                    idx_d   = 5'd0;
                    if (pre_base == 5'd0) prm_d = 1'b1;
                end else begin
                    state_d = ST_DROP;
                    prm_d   = 1'b1;
                end
            end
            ST_HDR: begin
                if (rx_dv) begin
                    crc_d  = crc_nxt;
                    flen_d = flen_inc;
                    sop_d  = (idx_q == 5'd0);
                    idx_d  = idx_q + 5'd1;
                    if (idx_q < 5'd6) begin
                        cur_d.dst = {cur_q.dst[39:0], rxd};
                    end else if (idx_q < 5'd12) begin
                        cur_d.src = {cur_q.src[39:0], rxd};
                    end else if (idx_q < 5'd14 || idx_q > 5'd15) begin
                        cur_d.len_type = lt_nxt;
                    end
                    // Bytes 14-15 of a tagged frame are the TCI and are skipped.
                    if (idx_q == 5'd13) begin
                        if (lt_nxt == TPID_VLAN) cur_d.vlan = 1'b1;
                        else                     state_d = ST_PAYLD;
                    end
                    if (idx_q == 5'd17) state_d = ST_PAYLD;
                end
            end
            ST_PAYLD: begin
                if (rx_dv) begin
                    crc_d    = crc_nxt;
                    flen_d   = flen_inc;
                    dl_dat_d = {dl_dat_q[2:0], rxd};
                    dl_vld_d = {dl_vld_q[2:0], 1'b1};
                    // Only bytes pushed out of the 4-deep line are known not to be FCS.
                    if (dl_vld_q[3]) begin
                        if ((cur_q.len_type >= LEN_TYPE_THR || pidx_q < cur_q.len_type) &&
                            dl_dat_q[3] != exp_q) begin
                            perr_d = 1'b1;
                        end
                        exp_d  = exp_q + cntstep;
                        pidx_d = (pidx_q == 16'hFFFF) ? pidx_q : pidx_q + 16'd1;
                    end
                end
            end
            default: ;
        endcase

        if (frm_end) begin
            state_d                 = ST_IDLE;
            pend_vld_d              = 1'b1;
            pend_hdr_d              = cur_q;
            pend_len_d              = flen_q;
            pend_meta_d.prmbl_err   = prm_q;
            pend_meta_d.crc_err     = (bit_rev32(crc_q) != CRC_RESIDUE) ||
                                      (state_q == ST_DROP) || (flen_q < 16'd18);
            pend_meta_d.payload_err = CHK_PAYLOAD && perr_q;
            pend_meta_d.phy_err     = phy_q;
            pend_meta_d.runt_err    = flen_q < MIN_L;
            pend_meta_d.long_err    = flen_q > MAX_L;
        end

        // Status stage runs on its own so a new preamble may overlap it.
        if (pend_vld_q) begin
            frm_done_d = 1'b1;
            out_hdr_d  = pend_hdr_q;
            out_meta_d = pend_meta_q;
            out_len_d  = pend_len_q;
            frm_cnt_d  = frm_cnt_q + 32'd1;
            if (|pend_meta_q) err_cnt_d = err_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pre_cnt_q   <= '0;
            idx_q       <= '0;
            crc_q       <= CRC_INIT;
            cur_q       <= '0;
            flen_q      <= '0;
            prm_q       <= 1'b0;
            phy_q       <= 1'b0;
            perr_q      <= 1'b0;
            exp_q       <= '0;
            pidx_q      <= '0;
            dl_dat_q    <= '0;
            dl_vld_q    <= '0;
            d1_act_q    <= 1'b0;
            sop_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_hdr_q  <= '0;
            pend_meta_q <= '0;
            pend_len_q  <= '0;
            frm_done_q  <= 1'b0;
            out_hdr_q   <= '0;
            out_meta_q  <= '0;
            out_len_q   <= '0;
            frm_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            idx_q       <= idx_d;
            crc_q       <= crc_d;
            cur_q       <= cur_d;
            flen_q      <= flen_d;
            prm_q       <= prm_d;
            phy_q       <= phy_d;
            perr_q      <= perr_d;
            exp_q       <= exp_d;
            pidx_q      <= pidx_d;
            dl_dat_q    <= dl_dat_d;
            dl_vld_q    <= dl_vld_d;
            d1_act_q    <= d1_act_d;
            sop_q       <= sop_d;
            pend_vld_q  <= pend_vld_d;
            pend_hdr_q  <= pend_hdr_d;
            pend_meta_q <= pend_meta_d;
            pend_len_q  <= pend_len_d;
            frm_done_q  <= frm_done_d;
            out_hdr_q   <= out_hdr_d;
            out_meta_q  <= out_meta_d;
            out_len_q   <= out_len_d;
            frm_cnt_q   <= frm_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // The registered previous byte is the last one when the live rx_dv has already dropped.
    assign eop         = d1_act_q && !rx_dv;
    assign sop         = sop_q;
    assign frm_done    = frm_done_q;
    assign dst         = out_hdr_q.dst;
    assign src         = out_hdr_q.src;
    assign len_type    = out_hdr_q.len_type;
    assign vlan_tag    = out_hdr_q.vlan;
    assign frm_len     = out_len_q;
    assign prmbl_err   = out_meta_q.prmbl_err;
    assign crc_err     = out_meta_q.crc_err;
    assign payload_err = out_meta_q.payload_err;
    assign phy_err     = out_meta_q.phy_err;
    assign runt_err    = out_meta_q.runt_err;
    assign long_err    = out_meta_q.long_err;
    assign frm_cnt     = frm_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_eth_gmii_monitor.sv
// Directed bench for eth_gmii_monitor: builds frames with a locally computed FCS.
// Latency: inputs change on the falling edge; outputs are sampled on the falling edge.
// Backpressure: none; every wait on frm_done is bounded.
module tb_eth_gmii_monitor;

    logic        rx_clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  cntstart;
    logic [7:0]  cntstep;
    logic        sop, eop, frm_done, vlan_tag;
    logic [47:0] dst, src;
    logic [15:0] len_type, frm_len;
    logic        prmbl_err, crc_err, payload_err, phy_err, runt_err, long_err;
    logic [31:0] frm_cnt, err_cnt;
    logic [5:0]  flg;

    localparam logic [47:0] EXP_DA = 48'h0011_2233_4455;
    localparam logic [47:0] EXP_SA = 48'h6677_8899_AABB;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int sop_cnt = 0;
    int eop_cnt = 0;
    logic [7:0] fb[$];
    logic [7:0] pb[$];

    eth_gmii_monitor #(.MAX_FRM_LEN(1518), .MIN_FRM_LEN(64), .CHK_PAYLOAD(1'b1)) dut (
        .rx_clk(rx_clk), .reset_n(reset_n), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
        .cntstart(cntstart), .cntstep(cntstep), .sop(sop), .eop(eop), .frm_done(frm_done),
        .dst(dst), .src(src), .len_type(len_type), .vlan_tag(vlan_tag), .frm_len(frm_len),
        .prmbl_err(prmbl_err), .crc_err(crc_err), .payload_err(payload_err), .phy_err(phy_err),
        .runt_err(runt_err), .long_err(long_err), .frm_cnt(frm_cnt), .err_cnt(err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    assign flg = {prmbl_err, crc_err, payload_err, phy_err, runt_err, long_err};

    always @(posedge rx_clk) begin
        if (frm_done) done_cnt++;
        if (sop) sop_cnt++;
        if (eop) eop_cnt++;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(negedge rx_clk);
        rx_dv = dv;
        rxd   = d;
        rx_er = er;
    endtask

    task automatic set_pre(input int n);
        pb.delete();
        for (int i = 0; i < n; i++) pb.push_back(8'h55);
        pb.push_back(8'hD5);
    endtask

    task automatic mk_hdr(input logic [15:0] lt);
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(8'(17 * i));
        for (int i = 0; i < 6; i++) fb.push_back(8'(8'h66 + 17 * i));
        fb.push_back(lt[15:8]);
        fb.push_back(lt[7:0]);
    endtask

    task automatic push_pay(input int n, input int nvalid, input logic [7:0] st, input logic [7:0] sp);
        logic [7:0] v;
        v = st;
        for (int i = 0; i < n; i++) begin
            fb.push_back((i < nvalid) ? v : 8'h00);
            v = v + sp;
        end
    endtask

    task automatic add_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (fb[i]) c = crc_upd(c, fb[i]);
        c = ~c;
        fb.push_back(c[7:0]);
        fb.push_back(c[15:8]);
        fb.push_back(c[23:16]);
        fb.push_back(c[31:24]);
    endtask

    task automatic std_frame(input int npay);
        mk_hdr(16'(npay));
        push_pay(npay, npay, 8'h01, 8'h01);
        add_fcs();
    endtask

    task automatic send(input int er_at);
        foreach (pb[i]) drive(1'b1, pb[i], 1'b0);
        foreach (fb[i]) drive(1'b1, fb[i], i == er_at);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge rx_clk);
            if (frm_done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge rx_clk);
        reset_n = 1'b0;
        @(negedge rx_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx_dv = 1'b0; rxd = 8'h00; rx_er = 1'b0;
        cntstart = 8'h01; cntstep = 8'h01;
        repeat (2) @(negedge rx_clk);
        checks++; if (frm_cnt !== 32'd0 || err_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", frm_cnt, err_cnt); end
        checks++; if ({frm_done, sop, eop} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {frm_done, sop, eop}); end
        checks++; if (flg !== 6'd0 || dst !== 48'd0 || frm_len !== 16'd0) begin failures++; $display("FAIL reset_status got flg=%b dst=%h len=%0d exp=0", flg, dst, frm_len); end
        reset_n = 1'b1;
    endtask

    task automatic test_good();
        int lat, s0, e0;
        s0 = sop_cnt; e0 = eop_cnt;
        set_pre(7); std_frame(46);
        send(-1); wait_done(lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL good_latency got=%0d exp=2", lat); end
        checks++; if (frm_len !== 16'd64) begin failures++; $display("FAIL good_len got=%0d exp=64", frm_len); end
        checks++; if (dst !== EXP_DA || src !== EXP_SA) begin failures++; $display("FAIL good_addr got=%h/%h exp=%h/%h", dst, src, EXP_DA, EXP_SA); end
        checks++; if (len_type !== 16'd46 || vlan_tag !== 1'b0) begin failures++; $display("FAIL good_lt got=%h/%b exp=002e/0", len_type, vlan_tag); end
        checks++; if (flg !== 6'd0) begin failures++; $display("FAIL good_flags got=%b exp=000000", flg); end
        checks++; if (frm_cnt !== 32'd1 || err_cnt !== 32'd0) begin failures++; $display("FAIL good_cnt got=%0d/%0d exp=1/0", frm_cnt, err_cnt); end
        checks++; if (sop_cnt - s0 !== 1 || eop_cnt - e0 !== 1) begin failures++; $display("FAIL good_sop_eop got=%0d/%0d exp=1/1", sop_cnt - s0, eop_cnt - e0); end
    endtask

    task automatic test_bad_fcs();
        int lat;
        set_pre(7); std_frame(46);
        fb[60] = ~fb[60];
        send(-1); wait_done(lat);
        checks++; if (flg !== 6'b010000) begin failures++; $display("FAIL fcs_flags got=%b exp=010000", flg); end
        checks++; if (err_cnt !== 32'd1 || frm_cnt !== 32'd2) begin failures++; $display("FAIL fcs_cnt got=%0d/%0d exp=1/2", err_cnt, frm_cnt); end
        checks++; if (dst !== EXP_DA || src !== EXP_SA || len_type !== 16'd46) begin failures++; $display("FAIL fcs_hdr got=%h/%h/%h", dst, src, len_type); end
    endtask

    task automatic test_payload();
        int lat;
        set_pre(7); mk_hdr(16'd46); push_pay(46, 46, 8'h01, 8'h01);
        fb[14+20] = 8'h00;
        add_fcs(); send(-1); wait_done(lat);
        checks++; if (flg !== 6'b001000) begin failures++; $display("FAIL pay_bad_flags got=%b exp=001000", flg); end
        cntstart = 8'h10; cntstep = 8'h03;
        mk_hdr(16'h0800); push_pay(100, 100, 8'h10, 8'h03); add_fcs();
        send(-1); wait_done(lat);
        checks++; if (flg !== 6'd0 || frm_len !== 16'd118 || len_type !== 16'h0800) begin failures++; $display("FAIL pay_type got flg=%b len=%0d lt=%h exp=0/118/0800", flg, frm_len, len_type); end
        cntstart = 8'h01; cntstep = 8'h01;
        mk_hdr(16'd10); push_pay(46, 10, 8'h01, 8'h01); add_fcs();
        send(-1); wait_done(lat);
        checks++; if (flg !== 6'd0 || frm_len !== 16'd64) begin failures++; $display("FAIL pay_pad got flg=%b len=%0d exp=0/64", flg, frm_len); end
    endtask

    task automatic test_prmbl();
        int lat;
        pb.delete(); pb.push_back(8'h55); pb.push_back(8'h55); pb.push_back(8'h5D); pb.push_back(8'hD5);
        std_frame(46); send(-1); wait_done(lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL prmbl_latency got=%0d exp=2", lat); end
        checks++; if (prmbl_err !== 1'b1 || crc_err !== 1'b1) begin failures++; $display("FAIL prmbl_bad got=%b/%b exp=1/1", prmbl_err, crc_err); end
        set_pre(0); std_frame(46); send(-1); wait_done(lat);
        checks++; if (flg !== 6'b100000 || frm_len !== 16'd64) begin failures++; $display("FAIL prmbl_nopre got flg=%b len=%0d exp=100000/64", flg, frm_len); end
    endtask

    task automatic test_vlan_runt();
        int lat;
        set_pre(7); mk_hdr(16'h8100);
        fb.push_back(8'h00); fb.push_back(8'h05); fb.push_back(8'h00); fb.push_back(8'h2E);
        push_pay(46, 46, 8'h01, 8'h01); add_fcs();
        send(-1); wait_done(lat);
        checks++; if (vlan_tag !== 1'b1 || len_type !== 16'h002E) begin failures++; $display("FAIL vlan_hdr got=%b/%h exp=1/002e", vlan_tag, len_type); end
        checks++; if (frm_len !== 16'd68 || flg !== 6'd0) begin failures++; $display("FAIL vlan_len got len=%0d flg=%b exp=68/0", frm_len, flg); end
        std_frame(22); send(-1); wait_done(lat);
        checks++; if (flg !== 6'b000010 || frm_len !== 16'd40 || vlan_tag !== 1'b0) begin failures++; $display("FAIL runt got flg=%b len=%0d vlan=%b exp=000010/40/0", flg, frm_len, vlan_tag); end
    endtask

    task automatic test_phy();
        int lat;
        set_pre(7); std_frame(46); send(14 + 10); wait_done(lat);
        checks++; if (flg !== 6'b000100) begin failures++; $display("FAIL phy got=%b exp=000100", flg); end
        drive(1'b0, 8'h00, 1'b1);
        std_frame(46); send(-1); wait_done(lat);
        checks++; if (flg !== 6'd0) begin failures++; $display("FAIL phy_idle_er got=%b exp=000000", flg); end
    endtask

    task automatic test_back_to_back();
        int lat, d0;
        do_reset();
        d0 = done_cnt;
        set_pre(7); std_frame(46); send(-1);
        std_frame(22); send(-1); wait_done(lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
        checks++; if (flg !== 6'b000010 || frm_len !== 16'd40) begin failures++; $display("FAIL b2b_status got flg=%b len=%0d exp=000010/40", flg, frm_len); end
        repeat (2) @(negedge rx_clk);
        checks++; if (done_cnt - d0 !== 2 || frm_cnt !== 32'd2 || err_cnt !== 32'd1) begin failures++; $display("FAIL b2b_cnt got done=%0d frm=%0d err=%0d exp=2/2/1", done_cnt - d0, frm_cnt, err_cnt); end
    endtask

    task automatic test_reset_mid();
        int d0;
        set_pre(7); std_frame(46);
        foreach (pb[i]) drive(1'b1, pb[i], 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b1, fb[i], 1'b0);
        @(negedge rx_clk);
        reset_n = 1'b0; rx_dv = 1'b0;
        d0 = done_cnt;
        repeat (2) @(negedge rx_clk);
        reset_n = 1'b1;
        repeat (8) @(negedge rx_clk);
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL rst_mid_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (frm_cnt !== 32'd0 || err_cnt !== 32'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0", frm_cnt, err_cnt); end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_fcs();
        test_payload();
        test_prmbl();
        test_vlan_runt();
        test_phy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
